// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM states, instruction
// field layout and default opcode masks.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [15:0] NOP_INS = 16'h0000;

  localparam int unsigned OP_LSB = 4;
  localparam int unsigned RA_LSB = 2;
  localparam int unsigned RB_LSB = 0;

  localparam logic [15:0] DEF_WB_OP_MASK = 16'h00FE;
  localparam logic [15:0] DEF_RA_RD_MASK = 16'hFFFE;
  localparam logic [15:0] DEF_RB_RD_MASK = 16'h00FE;
  localparam int unsigned DEF_WB_DIST    = 3;

  function automatic logic [3:0] ins_op(input logic [15:0] ins);
    return ins[OP_LSB +: 4];
  endfunction

  function automatic logic [1:0] ins_ra(input logic [15:0] ins);
    return ins[RA_LSB +: 2];
  endfunction

  function automatic logic [1:0] ins_rb(input logic [15:0] ins);
    return ins[RB_LSB +: 2];
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard: counts down the cycles until an issued write
// lands in the register file and flags ID-stage readers of pending registers.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter logic [15:0] WB_OP_MASK = DEF_WB_OP_MASK,
  parameter logic [15:0] RA_RD_MASK = DEF_RA_RD_MASK,
  parameter logic [15:0] RB_RD_MASK = DEF_RB_RD_MASK,
  parameter int unsigned WB_DIST    = DEF_WB_DIST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_ins,
  input  logic        id_valid,
  input  logic        issue,
  output logic        hazard
);

  localparam logic [1:0] LOAD_VAL = 2'(WB_DIST);

  logic [1:0] pend [4];
  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic       unused_imm;

  assign op         = ins_op(id_ins);
  assign ra         = ins_ra(id_ins);
  assign rb         = ins_rb(id_ins);
  assign unused_imm = ^id_ins[15:8];

  // A fresh load on the issuing writer's destination wins over the decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (issue && WB_OP_MASK[op] && (ra == 2'(i)))
          pend[i] <= LOAD_VAL;
        else if (pend[i] != '0)
          pend[i] <= pend[i] - 2'd1;
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (RA_RD_MASK[op] && (pend[ra] != '0)) hazard = 1'b1;
      if (RB_RD_MASK[op] && (pend[rb] != '0)) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencing controller: RUN/HOLD/STEP control FSM, hold/flush/bubble
// decode for PC, IF/ID and ID/EXE, and a saturating hazard-stall counter.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter logic [15:0] WB_OP_MASK = DEF_WB_OP_MASK,
  parameter logic [15:0] RA_RD_MASK = DEF_RA_RD_MASK,
  parameter logic [15:0] RB_RD_MASK = DEF_RB_RD_MASK,
  parameter int unsigned WB_DIST    = DEF_WB_DIST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_ins,
  input  logic        id_valid,
  input  logic        br_taken,
  input  logic        step_mode,
  input  logic        step_req,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        br_allow,
  output logic        issue,
  output logic [7:0]  stall_cnt,
  output logic [1:0]  state_o
);

  state_t state;
  logic   hazard;
  logic   can_go;

  hazard_scoreboard #(
    .WB_OP_MASK (WB_OP_MASK),
    .RA_RD_MASK (RA_RD_MASK),
    .RB_RD_MASK (RB_RD_MASK),
    .WB_DIST    (WB_DIST)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .id_ins   (id_ins),
    .id_valid (id_valid),
    .issue    (issue),
    .hazard   (hazard)
  );

  // Outputs are forced low for the whole reset window, not just until the next edge.
  always_comb begin
    can_go      = (state != HOLD) && !hazard;
    issue       = 1'b0;
    br_allow    = 1'b0;
    ifid_flush  = 1'b0;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      issue       = can_go && id_valid;
      br_allow    = can_go && id_valid;
      ifid_flush  = br_taken && can_go && id_valid;
      pc_hold     = !can_go;
      ifid_hold   = !can_go;
      idex_bubble = !can_go;
    end
  end

  assign state_o = state;

  // An empty ID slot leaves STEP just like a real issue, so STEP exits on can_go.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      if (hazard && (state != HOLD) && (stall_cnt != 8'hFF))
        stall_cnt <= stall_cnt + 8'd1;
      unique case (state)
        RUN:  if (step_mode) state <= HOLD;
        HOLD: begin
          if (step_req)        state <= STEP;
          else if (!step_mode) state <= RUN;
        end
        STEP: if (can_go) state <= step_mode ? HOLD : RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed vector table, hand-written corner
// sequences, then random stimulus against a timestamp-based reference model.
module tb_hazard_sequencer;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] id_ins = '0;
  logic        id_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        step_mode = 1'b0;
  logic        step_req = 1'b0;
  logic        pc_hold, ifid_hold, ifid_flush, idex_bubble, br_allow, issue;
  logic [7:0]  stall_cnt;
  logic [1:0]  state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_sequencer #(
    .WB_OP_MASK (16'h00FE),
    .RA_RD_MASK (16'hFFFE),
    .RB_RD_MASK (16'h00FE),
    .WB_DIST    (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_ins      (id_ins),
    .id_valid    (id_valid),
    .br_taken    (br_taken),
    .step_mode   (step_mode),
    .step_req    (step_req),
    .pc_hold     (pc_hold),
    .ifid_hold   (ifid_hold),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .br_allow    (br_allow),
    .issue       (issue),
    .stall_cnt   (stall_cnt),
    .state_o     (state_o)
  );

  // {state, stall_cnt, issue, pc_hold, ifid_hold, idex_bubble, ifid_flush, br_allow}
  function automatic logic [15:0] obs_pack(input logic [1:0] st, input logic [7:0] cnt,
                                           input logic iss, input logic hold,
                                           input logic fl, input logic al);
    return {st, cnt, iss, hold, hold, hold, fl, al};
  endfunction

  function automatic logic [15:0] obs_dut();
    return {state_o, stall_cnt, issue, pc_hold, ifid_hold, idex_bubble, ifid_flush, br_allow};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] ins, input logic v, input logic br,
                       input logic sm, input logic sr);
    id_ins = ins; id_valid = v; br_taken = br; step_mode = sm; step_req = sr;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    rst = 1'b1;
    drive(NOP_INS, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ins;
    logic v, br, sm, sr;
    logic e_iss, e_hold, e_fl, e_al;
    logic [1:0] e_st;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [15:0] ins, input logic v, input logic br,
                              input logic sm, input logic sr, input logic iss,
                              input logic hold, input logic fl, input logic al,
                              input logic [1:0] st, input logic [7:0] cnt);
    vec_t r;
    r.ins = ins; r.v = v; r.br = br; r.sm = sm; r.sr = sr;
    r.e_iss = iss; r.e_hold = hold; r.e_fl = fl; r.e_al = al; r.e_st = st; r.e_cnt = cnt;
    return r;
  endfunction

  // Reference model: absolute cycle at which each register's write becomes readable.
  int unsigned ready_at[4];
  int unsigned cyc;
  int          mode;       // 0 running, 1 held, 2 single-stepping
  int          stalls;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ready_at[i] = 0;
    cyc = 0; mode = 0; stalls = 0;
  endtask

  function automatic bit model_hazard();
    int op = int'(id_ins[7:4]);
    int ra = int'(id_ins[3:2]);
    int rb = int'(id_ins[1:0]);
    if (!id_valid) return 1'b0;
    return (DEF_RA_RD_MASK[op] && cyc < ready_at[ra]) ||
           (DEF_RB_RD_MASK[op] && cyc < ready_at[rb]);
  endfunction

  initial begin
    logic [15:0] exp;
    logic [7:0]  prev_cnt;
    bit hz, go;
    int op;

    // Reset holds all control outputs low even with a valid instruction present.
    rst = 1'b1;
    drive(16'h0014, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    check("reset_outputs", obs_dut(), obs_pack(2'd0, 8'd0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    drive(NOP_INS, 1'b0, 1'b0, 1'b0, 1'b0);

    //      ins      v  br sm sr iss hold fl al st cnt
    vt.push_back(mk(16'h0014, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));  // independent pair
    vt.push_back(mk(16'h0028, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) vt.push_back(mk(NOP_INS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(16'h0014, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));  // writer r1
    vt.push_back(mk(16'h0024, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));  // reader stalls 3
    vt.push_back(mk(16'h0024, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vt.push_back(mk(16'h0024, 1, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    vt.push_back(mk(16'h0024, 1, 0, 0, 0, 1, 0, 0, 1, 0, 3));
    for (int i = 0; i < 3; i++) vt.push_back(mk(NOP_INS, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    vt.push_back(mk(16'h4080, 1, 1, 0, 0, 1, 0, 1, 1, 0, 3));  // clean branch
    vt.push_back(mk(16'h0010, 1, 0, 0, 0, 1, 0, 0, 1, 0, 3));  // writer r0
    vt.push_back(mk(16'h4080, 1, 1, 0, 0, 0, 1, 0, 0, 0, 3));  // branch suppressed
    vt.push_back(mk(16'h4080, 1, 1, 0, 0, 0, 1, 0, 0, 0, 4));
    vt.push_back(mk(16'h4080, 1, 1, 0, 0, 0, 1, 0, 0, 0, 5));
    vt.push_back(mk(16'h4080, 1, 1, 0, 0, 1, 0, 1, 1, 0, 6));
    vt.push_back(mk(NOP_INS, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6));   // enter step mode
    vt.push_back(mk(16'h0014, 1, 0, 1, 0, 0, 1, 0, 0, 1, 6));
    vt.push_back(mk(16'h0014, 1, 0, 1, 1, 0, 1, 0, 0, 1, 6));
    vt.push_back(mk(16'h0014, 1, 0, 1, 0, 1, 0, 0, 1, 2, 6));  // single release
    vt.push_back(mk(16'h0014, 1, 0, 1, 0, 0, 1, 0, 0, 1, 6));  // hazard in HOLD not counted
    vt.push_back(mk(16'h0014, 1, 0, 0, 0, 0, 1, 0, 0, 1, 6));
    vt.push_back(mk(16'h0014, 1, 0, 0, 0, 0, 1, 0, 0, 0, 6));
    vt.push_back(mk(16'h0014, 1, 0, 0, 0, 1, 0, 0, 1, 0, 7));

    foreach (vt[k]) begin
      drive(vt[k].ins, vt[k].v, vt[k].br, vt[k].sm, vt[k].sr);
      @(negedge clk);
      check($sformatf("vec%0d", k), obs_dut(),
            obs_pack(vt[k].e_st, vt[k].e_cnt, vt[k].e_iss, vt[k].e_hold, vt[k].e_fl, vt[k].e_al));
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of a stall.
    do_reset();
    drive(16'h0014, 1, 0, 0, 0);
    @(posedge clk); #1;
    drive(16'h0024, 1, 0, 0, 0);
    @(negedge clk);
    check("pre_async_stall", obs_dut(), obs_pack(2'd0, 8'd0, 0, 1, 0, 0));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async_reset_clear", obs_dut(), obs_pack(2'd0, 8'd0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_reader", obs_dut(), obs_pack(2'd0, 8'd0, 1, 0, 0, 1));
    @(posedge clk); #1;

    // Stall counter saturation: a self-writing reader re-arms its own hazard.
    do_reset();
    drive(16'h0024, 1, 0, 0, 0);
    prev_cnt = 8'd0;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      if (stall_cnt < prev_cnt) check("stall_no_wrap", {8'd0, stall_cnt}, {8'd0, prev_cnt});
      prev_cnt = stall_cnt;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("stall_saturated", {8'd0, stall_cnt}, 16'h00FF);
    @(posedge clk); #1;

    // Random stimulus against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      id_ins   = 16'($urandom);
      id_valid = ($urandom_range(0, 9) < 8);
      br_taken = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
      step_req = step_mode && ($urandom_range(0, 5) == 0);
      @(negedge clk);
      hz = model_hazard();
      go = (mode != 1) && !hz;
      exp = obs_pack(2'(mode), (stalls > 255) ? 8'hFF : 8'(stalls),
                     go && id_valid, !go, go && id_valid && br_taken, go && id_valid);
      check("random", obs_dut(), exp);
      op = int'(id_ins[7:4]);
      if (go && id_valid && DEF_WB_OP_MASK[op])
        ready_at[int'(id_ins[3:2])] = cyc + DEF_WB_DIST + 1;
      if (hz && mode != 1) stalls++;
      case (mode)
        0: if (step_mode) mode = 1;
        1: if (step_req) mode = 2; else if (!step_mode) mode = 0;
        default: if (go) mode = step_mode ? 1 : 0;
      endcase
      cyc++;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
